// File: rtl/exotiny_pkg.sv
// rtl/exotiny_pkg.sv - shared types and constants for the exotiny QSPI memory controller
//
// Purpose: FSM state enum, default QPI command bytes, per-phase nibble counts
// and a byte-swap helper used when moving little-endian words through the
// MSB-first nibble shifter.
// Ports: none (package).
package exotiny_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } qspi_state_t;

  localparam logic [7:0] CMD_READ_DEF  = 8'hEB;
  localparam logic [7:0] CMD_WRITE_DEF = 8'h38;

  localparam int CMD_NIBS  = 2;
  localparam int ADDR_NIBS = 6;
  localparam int DATA_NIBS = 8;

  // Counter values on the last nibble of each fixed-length phase.
  localparam logic [7:0] CMD_LAST  = 8'(CMD_NIBS - 1);
  localparam logic [7:0] ADDR_LAST = 8'(ADDR_NIBS - 1);
  localparam logic [7:0] DATA_LAST = 8'(DATA_NIBS - 1);

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/qspi_nib_shreg.sv
// rtl/qspi_nib_shreg.sv - 32-bit nibble shift register for QPI tx and rx
//
// Purpose: parallel load (optionally byte-swapped) then shift out MSB nibble
// first; or shift nibbles in at the LSB end. word_o presents the byte-swapped
// word that results from shifting nib_i in on the current step, so the final
// received nibble can be folded into the read word on the same clock edge.
// Ports:
//   clk_i, rst_in  clock, asynchronous active-low reset
//   load_i         parallel load (priority over shift)
//   swap_i         byte-swap load_data_i on load
//   load_data_i    32-bit load value
//   shift_i        shift one nibble: out at MSB, nib_i in at LSB
//   nib_i          incoming nibble
//   nib_o          current MSB nibble (tx data)
//   word_o         byte-swapped value including nib_i (rx data)
module qspi_nib_shreg
  import exotiny_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        load_i,
  input  logic        swap_i,
  input  logic [31:0] load_data_i,
  input  logic        shift_i,
  input  logic [3:0]  nib_i,
  output logic [3:0]  nib_o,
  output logic [31:0] word_o
);

  logic [31:0] r_sh;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_sh <= 32'h0;
    end else if (load_i) begin
      r_sh <= swap_i ? bswap32(load_data_i) : load_data_i;
    end else if (shift_i) begin
      r_sh <= {r_sh[27:0], nib_i};
    end
  end

  assign nib_o  = r_sh[31:28];
  assign word_o = bswap32({r_sh[27:0], nib_i});

endmodule

// File: rtl/qspi_mem_ctrl.sv
// rtl/qspi_mem_ctrl.sv - QPI controller turning word bus requests into ROM/RAM transfers
//
// Purpose: sequences CMD, ADDR, optional DUMMY and DATA nibbles at clk_i/2,
// selecting ROM or RAM by addr_i[24]. Writes to ROM complete immediately
// without touching the pins.
// Ports:
//   clk_i, rst_in          clock, asynchronous active-low reset
//   req_i, we_i            request (held until ack_o), write enable
//   addr_i[24:0]           [24] target (0 ROM, 1 RAM), [23:2] word address
//   wdata_i, rdata_o       write data in, read data out (held until next read)
//   ack_o                  one-cycle completion pulse
//   mem_cs_rom_on/ram_on   active-low chip selects
//   mem_sck_o              SPI clock
//   mem_sd_o/oen_o/sd_i    quad data out, per-line drive enable, data in
module qspi_mem_ctrl
  import exotiny_pkg::*;
#(
  parameter int         DUMMY_CYC = 4,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [24:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        mem_cs_rom_on,
  output logic        mem_cs_ram_on,
  output logic        mem_sck_o,
  output logic [3:0]  mem_sd_o,
  output logic [3:0]  mem_sd_oen_o,
  input  logic [3:0]  mem_sd_i
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

  qspi_state_t r_state;
  logic [7:0]  r_cnt;
  logic        r_ph;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_cs_rom;
  logic        r_cs_ram;
  logic        r_sck;
  logic [3:0]  r_oen;
  logic        r_ack;
  logic [31:0] r_rdata;

  logic        w_start;
  logic        w_rom_wr;
  logic        w_load;
  logic        w_swap;
  logic        w_shift;
  logic [31:0] w_load_data;
  logic [7:0]  w_cmd;
  logic [3:0]  w_nib;
  logic [31:0] w_word;

  assign w_rom_wr = we_i && !addr_i[24];
  assign w_start  = (r_state == ST_IDLE) && req_i && !w_rom_wr;
  assign w_cmd    = we_i ? CMD_WRITE : CMD_READ;

  // Command+address go out as-is; write data is byte-swapped in at the end
  // of ADDR so the little-endian word leaves low byte first.
  assign w_load = w_start ||
                  ((r_state == ST_ADDR) && r_ph && (r_cnt == ADDR_LAST) && r_we);
  assign w_swap = (r_state == ST_ADDR);
  // The two address LSBs are forced to zero on the wire.
  assign w_load_data = (r_state == ST_IDLE) ?
                       {w_cmd, addr_i[23:2], addr_i[1:0] & 2'b00} : r_wdata;
  // Shift at the end of every SCK phase 1 except during dummy cycles.
  assign w_shift = r_ph && ((r_state == ST_CMD) || (r_state == ST_ADDR) ||
                            (r_state == ST_DATA));

  qspi_nib_shreg u_shreg (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .load_i      (w_load),
    .swap_i      (w_swap),
    .load_data_i (w_load_data),
    .shift_i     (w_shift),
    .nib_i       (mem_sd_i),
    .nib_o       (w_nib),
    .word_o      (w_word)
  );

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 8'd0;
      r_ph     <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= 32'h0;
      r_cs_rom <= 1'b1;
      r_cs_ram <= 1'b1;
      r_sck    <= 1'b0;
      r_oen    <= 4'h0;
      r_ack    <= 1'b0;
      r_rdata  <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (req_i) begin
            r_we    <= we_i;
            r_wdata <= wdata_i;
            if (w_rom_wr) begin
              r_ack   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cs_rom <= addr_i[24];
              r_cs_ram <= !addr_i[24];
              r_oen    <= 4'hF;
              r_sck    <= 1'b0;
              r_ph     <= 1'b0;
              r_cnt    <= 8'd0;
              r_state  <= ST_CMD;
            end
          end
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
          if (!r_ph) begin
            r_sck <= 1'b1;
            r_ph  <= 1'b1;
          end else begin
            r_sck <= 1'b0;
            r_ph  <= 1'b0;
            r_cnt <= r_cnt + 8'd1;
            case (r_state)
              ST_CMD: begin
                if (r_cnt == CMD_LAST) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_ADDR;
                end
              end
              ST_ADDR: begin
                if (r_cnt == ADDR_LAST) begin
                  r_cnt <= 8'd0;
                  if (r_we) begin
                    r_state <= ST_DATA;
                  end else begin
                    r_oen   <= 4'h0;
                    r_state <= (DUMMY_CYC > 0) ? ST_DUMMY : ST_DATA;
                  end
                end
              end
              ST_DUMMY: begin
                if (r_cnt == DUMMY_LAST) begin
                  r_cnt   <= 8'd0;
                  r_state <= ST_DATA;
                end
              end
              ST_DATA: begin
                if (r_cnt == DATA_LAST) begin
                  r_cnt    <= 8'd0;
                  r_cs_rom <= 1'b1;
                  r_cs_ram <= 1'b1;
                  r_oen    <= 4'h0;
                  r_ack    <= 1'b1;
                  if (!r_we) begin
                    r_rdata <= w_word;
                  end
                  r_state  <= ST_DONE;
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_DONE: begin
          // Always pass through IDLE so CS stays high for two cycles.
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o       = r_rdata;
  assign ack_o         = r_ack;
  assign mem_cs_rom_on = r_cs_rom;
  assign mem_cs_ram_on = r_cs_ram;
  assign mem_sck_o     = r_sck;
  assign mem_sd_o      = w_nib;
  assign mem_sd_oen_o  = r_oen;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// tb/tb_qspi_mem_ctrl.sv - scoreboard bench for qspi_mem_ctrl
module tb_qspi_mem_ctrl;

  typedef struct packed {
    logic [31:0]  ack_cyc;
    logic         is_rd;
    logic [31:0]  rd;
    logic [7:0]   n;
    logic [127:0] nib;
    logic [127:0] oen;
    logic [1:0]   cs_sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req8, we;
  logic [24:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sd_i;
  logic [31:0] rdata, rdata8;
  logic        ack, ack8;
  logic        cs_rom, cs_ram, cs_rom8, cs_ram8;
  logic        sck, sck8;
  logic [3:0]  sd_o, oen, sd_o8, oen8;
  logic [3:0]  sd_i8;
  logic [31:0] model_rd;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sd_i8 = 4'hA;

  qspi_mem_ctrl dut (
    .clk_i(clk), .rst_in(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack),
    .mem_cs_rom_on(cs_rom), .mem_cs_ram_on(cs_ram), .mem_sck_o(sck),
    .mem_sd_o(sd_o), .mem_sd_oen_o(oen), .mem_sd_i(sd_i)
  );

  qspi_mem_ctrl #(.DUMMY_CYC(8)) dut8 (
    .clk_i(clk), .rst_in(rst_n), .req_i(req8), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata8), .ack_o(ack8),
    .mem_cs_rom_on(cs_rom8), .mem_cs_ram_on(cs_ram8), .mem_sck_o(sck8),
    .mem_sd_o(sd_o8), .mem_sd_oen_o(oen8), .mem_sd_i(sd_i8)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic push_exp(input int lat, input logic is_rd, input logic [31:0] rd,
                          input int n, input logic [127:0] nib, input logic [127:0] oe,
                          input logic [1:0] sel);
    exp_t e;
    e.ack_cyc = 32'(cyc + lat);
    e.is_rd   = is_rd;
    e.rd      = rd;
    e.n       = 8'(n);
    e.nib     = nib;
    e.oen     = oe;
    e.cs_sel  = sel;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s ack timeout actual=none required=ack", name);
    end
  endtask

  // Pin monitor, memory model and scoreboard checker: one entry per ack.
  initial begin : monitor
    logic [127:0] obs_n, obs_o;
    logic [1:0]   used;
    int           k, d;
    exp_t         e;
    k = 0; obs_n = '0; obs_o = '0; used = 2'b00; sd_i = 4'h0;
    forever begin
      @(negedge clk);
      if (ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack actual=ack required=none cycle=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
          chk("nib_count", 128'(k), 128'(e.n));
          chk("cs_sel", 128'(used), 128'(e.cs_sel));
          if (e.is_rd) chk("rdata", 128'(rdata), 128'(e.rd));
          for (int i = 0; i < int'(e.n); i++) begin
            chk($sformatf("oen[%0d]", i), 128'(obs_o[127-4*i -: 4]), 128'(e.oen[127-4*i -: 4]));
            if (e.oen[127-4*i -: 4] == 4'hF)
              chk($sformatf("sd_o[%0d]", i), 128'(obs_n[127-4*i -: 4]), 128'(e.nib[127-4*i -: 4]));
          end
        end
        k = 0; obs_n = '0; obs_o = '0; used = 2'b00;
      end else if (cs_rom && cs_ram) begin
        k = 0; obs_n = '0; obs_o = '0; used = 2'b00;
      end else if (!sck) begin
        if (k < 32) begin
          obs_n[127-4*k -: 4] = sd_o;
          obs_o[127-4*k -: 4] = oen;
        end
        used = used | {~cs_rom, ~cs_ram};
        // Read data starts after 8 cmd/addr nibbles and 4 dummy cycles;
        // bytes go out low byte first, high nibble of each byte first.
        d = k - 12;
        if (d >= 0 && d < 8) sd_i = model_rd[8*(d/2) + ((d % 2) ? 0 : 4) +: 4];
        else sd_i = 4'h0;
        k++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int c0;
    bit seen;
    rst_n = 1'b0; req = 1'b0; req8 = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; model_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_rom", 128'(cs_rom), 128'(1));
    chk("rst_cs_ram", 128'(cs_ram), 128'(1));
    chk("rst_sck", 128'(sck), 128'(0));
    chk("rst_sd_o", 128'(sd_o), 128'(0));
    chk("rst_oen", 128'(oen), 128'(0));
    chk("rst_ack", 128'(ack), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ROM read at 0x0000100, memory returns bytes 13 05 00 00.
    model_rd = 32'h0000_0513;
    push_exp(41, 1'b1, 32'h0000_0513, 20, {32'hEB00_0100, 96'h0}, {32'hFFFF_FFFF, 96'h0}, 2'b10);
    we = 1'b0; addr = 25'h000_0100; req = 1'b1;
    wait_ack("rom_read");
    req = 1'b0;
    repeat (3) @(negedge clk);

    // RAM write; req dropped early, which must be ignored.
    push_exp(33, 1'b0, 32'h0, 16, {64'h3800_0010_EFBE_ADDE, 64'h0},
             {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, 2'b01);
    we = 1'b1; addr = 25'h100_0010; wdata = 32'hDEAD_BEEF; req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    wait_ack("ram_write");
    chk("rdata_hold", 128'(rdata), 128'(32'h0000_0513));
    repeat (3) @(negedge clk);

    // ROM write: immediate ack, no pin activity.
    push_exp(1, 1'b0, 32'h0, 0, '0, '0, 2'b00);
    we = 1'b1; addr = 25'h0AB_CDE4; wdata = 32'h1234_5678; req = 1'b1;
    wait_ack("rom_write");
    chk("rom_wr_sck", 128'(sck), 128'(0));
    chk("rom_wr_cs", 128'({cs_rom, cs_ram}), 128'(2'b11));
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset pulse in cycle 20 of a read: abort with no ack.
    we = 1'b0; addr = 25'h000_0100; req = 1'b1;
    repeat (20) @(negedge clk);
    chk("pre_abort_cs", 128'(cs_rom), 128'(0));
    rst_n = 1'b0;
    #1;
    chk("abort_cs_rom", 128'(cs_rom), 128'(1));
    chk("abort_cs_ram", 128'(cs_ram), 128'(1));
    chk("abort_sck", 128'(sck), 128'(0));
    chk("abort_oen", 128'(oen), 128'(0));
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    // Read after reset.
    model_rd = 32'hCAFE_1234;
    push_exp(41, 1'b1, 32'hCAFE_1234, 20, {32'hEB00_0200, 96'h0}, {32'hFFFF_FFFF, 96'h0}, 2'b10);
    we = 1'b0; addr = 25'h000_0200; req = 1'b1;
    wait_ack("read_after_reset");
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back: req stays high across ack with a RAM read queued.
    model_rd = 32'h0000_0513;
    push_exp(41, 1'b1, 32'h0000_0513, 20, {32'hEB00_0100, 96'h0}, {32'hFFFF_FFFF, 96'h0}, 2'b10);
    push_exp(83, 1'b1, 32'h89AB_CDEF, 20, {32'hEB00_0040, 96'h0}, {32'hFFFF_FFFF, 96'h0}, 2'b01);
    we = 1'b0; addr = 25'h000_0100; req = 1'b1;
    wait_ack("b2b_first");
    chk("b2b_cs_done", 128'({cs_rom, cs_ram}), 128'(2'b11));
    addr = 25'h100_0040;
    model_rd = 32'h89AB_CDEF;
    @(negedge clk);
    chk("b2b_cs_idle", 128'({cs_rom, cs_ram}), 128'(2'b11));
    @(negedge clk);
    chk("b2b_cs_next", 128'({cs_rom, cs_ram}), 128'(2'b10));
    wait_ack("b2b_second");
    req = 1'b0;
    repeat (3) @(negedge clk);

    // DUMMY_CYC=8 instance: ack in cycle 49, all-A nibbles read back.
    we = 1'b0; addr = 25'h000_0100; req8 = 1'b1;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (ack8) seen = 1'b1;
    end
    chk("dut8_ack_seen", 128'(seen), 128'(1));
    chk("dut8_ack_cycle", 128'(cyc - c0), 128'(49));
    chk("dut8_rdata", 128'(rdata8), 128'(32'hAAAA_AAAA));
    req8 = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_mem_ctrl.md
Name: qspi_mem_ctrl

Overview:
Quad-SPI memory controller inside exotiny, directly upstream of the chip-level pins. It turns word-wide bus requests from the core into QPI transactions to an external ROM (flash) and RAM. It drives mem_cs_rom_on, mem_cs_ram_on, mem_sck_o, mem_sd_o and mem_sd_oen_o, and samples mem_sd_i. Both devices are already in QPI mode at boot; command, address and data all travel 4 bits per SCK.

Parameters:
DUMMY_CYC, 4, SCK cycles of turnaround between address and read data
CMD_READ, 8'hEB, quad read command (ROM and RAM)
CMD_WRITE, 8'h38, quad write command (RAM only)

Ports:
clk_i  in  1  system clock
rst_in  in  1  reset, asynchronous, active-low
req_i  in  1  bus request; held high until ack_o
we_i  in  1  1=write, 0=read
addr_i  in  25  bit 24 selects target (0=ROM, 1=RAM); bits 23:2 word address; bits 1:0 ignored and sent as 0
wdata_i  in  32  write data
rdata_o  out  32  read data, valid while ack_o=1
ack_o  out  1  one-cycle completion pulse
mem_cs_rom_on  out  1  ROM chip select, active-low
mem_cs_ram_on  out  1  RAM chip select, active-low
mem_sck_o  out  1  SPI clock, clk_i/2 during transfers
mem_sd_o  out  4  quad data out
mem_sd_oen_o  out  4  output enable per line (1=drive)
mem_sd_i  in  4  quad data in

Behaviour:
- Interface: one clock, clk_i; reset rst_in is asynchronous and active-low.
- Reset values: both CS=1, sck=0, sd_o=0, sd_oen=0, ack_o=0, rdata_o=0, state IDLE. Assertion mid-transfer aborts at once; CS goes high asynchronously.
- States: IDLE -> CMD(2 nib) -> ADDR(6 nib) -> [read: DUMMY(DUMMY_CYC)] -> DATA(8 nib) -> DONE -> IDLE.
- Cycle 0 is the IDLE cycle that samples req_i=1. addr/we/wdata are latched there. The selected CS goes low in cycle 1.
- Each SCK cycle uses two clk cycles. Phase 0: sck=0, new nibble on sd_o. Phase 1: sck=1. Read nibbles are captured on the clk edge that ends phase 1.
- N = 16+DUMMY_CYC for reads, 16 for writes. The transfer occupies cycles 1..2N.
- DONE is cycle 2N+1: CS=1, sck=0, ack_o=1, rdata_o valid. With DUMMY_CYC=4, a read acks at cycle 41 and a write at cycle 33.
- Nibble order is MSB nibble first for cmd and addr. Data is little-endian by byte, high nibble of each byte first.
- sd_oen=4'hF during CMD, ADDR and write DATA; 4'h0 during DUMMY, read DATA and idle.
- ROM write (we_i=1, addr_i[24]=0): no CS activity; ack_o in cycle 1; data discarded.
- req_i deasserted mid-transfer is illegal and ignored; the transfer completes.
- Back-to-back: DONE always passes through IDLE, so CS stays high at least 2 cycles between transactions.
- rdata_o holds its value until the next read's DONE.

Decomposition:
- exotiny_pkg holds the qspi_state_t enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE), the default CMD_READ/CMD_WRITE constants, and the nibble-count localparams.
- One sub-module, qspi_nib_shreg: a 32-bit register shifting 4 bits per step. It handles both parallel-load/shift-out (tx) and shift-in (rx), with byte-swap on load and unload. The FSM, nibble counter and sck toggle stay in qspi_mem_ctrl.

Test Plan:
- ROM read at addr 0x0000100; model returns bytes 13,05,00,00. Required: sd_o nibbles E,B,0,0,0,1,0,0; 4 dummy cycles with oen=0; rx nibbles 1,3,0,5,0,0,0,0; ack in cycle 41 with rdata_o=0x00000513; only cs_rom low.
- RAM write at addr 0x1000010, wdata 0xDEADBEEF. Required: nibbles 3,8,0,0,0,0,1,0,E,F,B,E,A,D,D,E; oen=F throughout; cs_ram low for cycles 1..32; ack in cycle 33.
- ROM write at any address. Required: both CS stay 1, sck stays 0, ack_o=1 in cycle 1.
- Reset pulse in cycle 20 of a read. Required: CS=1 and sck=0 immediately; no ack; a following read completes correctly.
- req_i held high across ack with a new read queued. Required: CS high for at least 2 cycles between transfers; second ack 42 cycles after the first.
- DUMMY_CYC=8 override. Required: read ack in cycle 49.
